// File: rtl/utxf_pkg.sv
// Shared types and constants for the UART transmit byte FIFO.
package utxf_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } out_state_e;

endpackage

// File: rtl/utxf_ram.sv
// Register-array storage for uart_tx_fifo: one synchronous write port and one asynchronous read port.
module utxf_ram
  import utxf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  // Contents need no reset; the level counter in the top decides what is valid.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter, with saturating overflow counter.
// Define UTXF_SYNC_EN to insert SYNC_BYTE before every FRAME_LEN payload bytes.
//
// state | meaning
// SYNC  | presenting SYNC_BYTE; storage untouched by its handshake
// DATA  | presenting buffered payload; pay_cnt counts popped bytes
module uart_tx_fifo
  import utxf_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter int               FRAME_LEN = 64,
  parameter logic [WIDTH-1:0] SYNC_BYTE = WIDTH'(SYNC_BYTE_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            drop_count,
  input  logic                   clr_drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_frame
    $error("uart_tx_fifo: FRAME_LEN must be in 1..65535");
  end

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [15:0]      r_drop_count;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic             w_payload_valid;
  logic [WIDTH-1:0] w_rd_data;

  assign full            = (r_level == LVL_FULL);
  assign empty           = (r_level == '0);
  assign level           = r_level;
  assign drop_count      = r_drop_count;
  assign w_payload_valid = !empty;
  // full is registered, so a simultaneous pop never rescues an incoming byte
  assign w_push          = in_valid && !full;
  assign w_drop          = in_valid && full;

  utxf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

`ifdef UTXF_SYNC_EN
  out_state_e r_state;
  out_state_e w_state_nxt;
  logic [15:0] r_pay_cnt;
  logic [15:0] w_pay_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SYNC;
      r_pay_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pay_cnt <= w_pay_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pay_cnt_nxt = r_pay_cnt;
    out_valid     = w_payload_valid;
    out_data      = w_payload_valid ? w_rd_data : '0;
    w_pop         = 1'b0;
    case (r_state)
      SYNC: begin
        out_valid = 1'b1;
        out_data  = SYNC_BYTE;
        if (out_ready) begin
          w_state_nxt   = DATA;
          w_pay_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_payload_valid && out_ready) begin
          w_pop         = 1'b1;
          w_pay_cnt_nxt = r_pay_cnt + 16'd1;
          if (w_pay_cnt_nxt == 16'(FRAME_LEN)) begin
            w_state_nxt = SYNC;
          end
        end
      end
      default: w_state_nxt = SYNC;
    endcase
  end
`else
  assign out_valid = w_payload_valid;
  assign out_data  = w_payload_valid ? w_rd_data : '0;
  assign w_pop     = w_payload_valid && out_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Clear wins over the old value, but an overflow in the same cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
    end else if (clr_drops) begin
      r_drop_count <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && r_drop_count != 16'hFFFF) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue scoreboard follows the stimulus and every output cycle is compared.
module tb_uart_tx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
`ifdef UTXF_SYNC_EN
  localparam int  FRAME   = 4;
  localparam bit  SYNC_EN = 1'b1;
`else
  localparam int  FRAME   = 64;
  localparam bit  SYNC_EN = 1'b0;
`endif
  localparam logic [7:0] SYNC_VAL = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       level;
  logic             full;
  logic             empty;
  logic [15:0]      drop_count;
  logic             clr_drops;

  uart_tx_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME),
    .SYNC_BYTE (SYNC_VAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count),
    .clr_drops  (clr_drops)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: scoreboard queue of bytes that must appear, in order.
  logic [7:0] sb[$];
  logic [7:0] cap[$];
  int         m_drops = 0;
  bit         m_sync  = SYNC_EN;
  int         m_pay   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      m_drops = 0;
      m_sync  = SYNC_EN;
      m_pay   = 0;
    end else begin
      bit m_full, m_hs, m_pop;
      m_full = (sb.size() == DEPTH);
      m_hs   = out_ready && (m_sync || sb.size() > 0);
      m_pop  = m_hs && !m_sync;
      if (m_pop) void'(sb.pop_front());
      if (in_valid && !m_full) sb.push_back(in_data);
      if (clr_drops) m_drops = (in_valid && m_full) ? 1 : 0;
      else if (in_valid && m_full && m_drops < 65535) m_drops++;
      if (m_sync && m_hs) begin
        m_sync = 1'b0;
        m_pay  = 0;
      end else if (m_pop) begin
        m_pay++;
        if (m_pay == FRAME) m_sync = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic       e_valid;
      logic [7:0] e_data;
      e_valid = m_sync || (sb.size() > 0);
      e_data  = m_sync ? SYNC_VAL : ((sb.size() > 0) ? sb[0] : 8'h00);
      check_eq("out_valid", 32'(out_valid), 32'(e_valid));
      check_eq("out_data", 32'(out_data), 32'(e_data));
      check_eq("level", 32'(level), 32'(sb.size()));
      check_eq("full", 32'(full), 32'(sb.size() == DEPTH));
      check_eq("empty", 32'(empty), 32'(sb.size() == 0));
      check_eq("drop_count", 32'(drop_count), 32'(m_drops));
      if (out_valid && out_ready) cap.push_back(out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_drops = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'(SYNC_EN));
    check_eq("rst_data", 32'(out_data), SYNC_EN ? 32'h0000_00A5 : 32'd0);
    check_eq("rst_drops", 32'(drop_count), 32'd0);
    tick();

`ifdef UTXF_SYNC_EN
    begin
      logic [7:0] exp_seq[$];
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
      repeat (12) tick();
      exp_seq.push_back(SYNC_VAL);
      for (int i = 0; i < 4; i++) exp_seq.push_back(8'(8'h10 + i));
      exp_seq.push_back(SYNC_VAL);
      for (int i = 4; i < 8; i++) exp_seq.push_back(8'(8'h10 + i));
      exp_seq.push_back(SYNC_VAL);
      check_eq("sync_count", 32'(cap.size()), 32'(exp_seq.size()));
      for (int i = 0; i < exp_seq.size() && i < cap.size(); i++)
        check_eq("sync_seq", 32'(cap[i]), 32'(exp_seq[i]));
      check_eq("sync_idle_empty", 32'(empty), 32'd1);
    end
`else
    // single byte, latency one cycle
    out_ready = 1'b1;
    push(8'h3C);
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_data", 32'(out_data), 32'h3C);
    tick();
    check_eq("t1_empty", 32'(empty), 32'd1);
    check_eq("t1_level", 32'(level), 32'd0);

    // burst under backpressure, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    check_eq("t2_full", 32'(full), 32'd1);
    check_eq("t2_level", 32'(level), 32'd16);
    check_eq("t2_head", 32'(out_data), 32'h01);
    tick();
    tick();
    check_eq("t2_hold_data", 32'(out_data), 32'h01);
    check_eq("t2_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("t2_order", 32'(out_data), 32'(i + 1));
      tick();
    end
    check_eq("t2_empty", 32'(empty), 32'd1);

    // overflow: three drops, one concurrent with a pop
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push(8'h90);
    push(8'h91);
    out_ready = 1'b1;
    push(8'h92);
    out_ready = 1'b0;
    check_eq("t3_drops", 32'(drop_count), 32'd3);
    check_eq("t3_level", 32'(level), 32'd15);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check_eq("t3_order", 32'(out_data), 32'(8'h21 + i));
      tick();
    end
    out_ready = 1'b0;
    check_eq("t3_empty", 32'(empty), 32'd1);
    clr_drops = 1'b1;
    tick();
    clr_drops = 1'b0;
    check_eq("t3_clr", 32'(drop_count), 32'd0);

    // clear coinciding with an overflow leaves one drop
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    clr_drops = 1'b1;
    push(8'hEE);
    clr_drops = 1'b0;
    check_eq("t3_clr_ovf", 32'(drop_count), 32'd1);

    // saturation
    in_data  = 8'h77;
    in_valid = 1'b1;
    repeat (65540) tick();
    check_eq("t4_sat", 32'(drop_count), 32'hFFFF);
    repeat (3) tick();
    in_valid = 1'b0;
    check_eq("t4_sat_hold", 32'(drop_count), 32'hFFFF);
    clr_drops = 1'b1;
    tick();
    clr_drops = 1'b0;
    check_eq("t4_clr", 32'(drop_count), 32'd0);

    // reset mid-stream
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    check_eq("t5_level_pre", 32'(level), 32'd5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t5_valid_rst", 32'(out_valid), 32'd0);
    check_eq("t5_level_rst", 32'(level), 32'd0);
    check_eq("t5_empty_rst", 32'(empty), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    push(8'hAA);
    check_eq("t5_first", 32'(out_data), 32'hAA);
    check_eq("t5_first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check_eq("t5_drain", 32'(empty), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
